// File: rtl/multiplier_pkg.sv
// multiplier_pkg
// Shared definitions for the shift-add multiplier slice:
//   state_t        - controller state encoding (IDLE, RUN, DONE)
//   counter_width  - width of the iteration counter for a given datapath
//                    width N, $clog2(N) with a floor of 1 bit
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only ever holds N-1 down to 0, so $clog2(N) bits suffice.
  // N=1 still needs one bit to hold the value 0.
  function automatic int counter_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiplier_counter.sv
// multiplier_counter
// Iteration counter for the shift-add multiplier. It is preset to N-1 when
// an operation is accepted and counts down once per RUN cycle. The
// controller stops decrementing when is_zero is high, so it never wraps.
// Ports:
//   clock        in  system clock
//   n_reset      in  synchronous, active-low reset (count -> 0)
//   do_preset    in  load N-1
//   do_decrement in  count -= 1
//   is_zero      out count equals 0
module multiplier_counter
  import multiplier_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clock,
  input  logic n_reset,
  input  logic do_preset,
  input  logic do_decrement,
  output logic is_zero
);

  localparam int W = counter_width(N);
  localparam logic [W-1:0] PRESET_VALUE = W'(N - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_count <= '0;
    end else if (do_preset) begin
      r_count <= PRESET_VALUE;
    end else if (do_decrement) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign is_zero = (r_count == '0);

endmodule

// File: rtl/multiplier_controller.sv
// multiplier_controller
// Sequencing FSM for the shift-add multiplier. It accepts an operation on a
// valid/ready handshake, runs N add/shift iterations paced by the sibling
// multiplier_counter, then presents the result on a valid/ready handshake.
// Every output is decoded combinationally from the state and the inputs.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (accept happens in IDLE)
//   out_valid/out_ready  result handshake (offered in DONE)
//   multiplier_lsb     current LSB of the datapath multiplier register
//   is_zero            counter at 0 (last iteration)
//   do_load/do_add/do_shift    datapath strobes
//   do_preset/do_decrement     counter strobes
//   busy               high while iterating
module multiplier_controller
  import multiplier_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  input  logic multiplier_lsb,
  input  logic is_zero,
  output logic do_load,
  output logic do_add,
  output logic do_shift,
  output logic do_preset,
  output logic do_decrement,
  output logic busy
);

  // The iteration count lives in multiplier_counter; N only has to be legal.
  if (N < 1) begin : g_bad_n
    $error("multiplier_controller: N must be at least 1");
  end

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    do_load      = 1'b0;
    do_add       = 1'b0;
    do_shift     = 1'b0;
    do_preset    = 1'b0;
    do_decrement = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          do_load   = 1'b1;
          do_preset = 1'b1;
          w_next    = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        do_shift = 1'b1;
        do_add   = multiplier_lsb;
        // Holding the count at 0 on the last iteration keeps the counter
        // from wrapping; the final shift/add still happens this cycle.
        if (is_zero) begin
          w_next = DONE;
        end else begin
          do_decrement = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_controller.sv
// tb_multiplier_controller
// Drives the controller together with multiplier_counter and a small
// behavioural shift-add datapath. Expected strobe sequences come from the
// operation's rules (accept, N iterations, done) and the product is
// compared against a*b.
module tb_multiplier_controller;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic multiplier_lsb;
  logic is_zero;
  logic do_load;
  logic do_add;
  logic do_shift;
  logic do_preset;
  logic do_decrement;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  multiplier_controller #(.N(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .multiplier_lsb(multiplier_lsb),
    .is_zero       (is_zero),
    .do_load       (do_load),
    .do_add        (do_add),
    .do_shift      (do_shift),
    .do_preset     (do_preset),
    .do_decrement  (do_decrement),
    .busy          (busy)
  );

  multiplier_counter #(.N(N)) u_counter (
    .clock       (clock),
    .n_reset     (~reset),
    .do_preset   (do_preset),
    .do_decrement(do_decrement),
    .is_zero     (is_zero)
  );

  // Behavioural datapath: operands are presented on op_a/op_b while in_valid.
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N:0]   dp_hi;
  logic [N-1:0] dp_lo;
  logic [N-1:0] dp_mcand;
  logic [N:0]   dp_sum;
  logic [2*N:0] dp_pair;
  logic [2*N-1:0] product;

  assign dp_sum         = dp_hi + (do_add ? {1'b0, dp_mcand} : '0);
  assign dp_pair        = {dp_sum, dp_lo} >> 1;
  assign multiplier_lsb = dp_lo[0];
  assign product        = {dp_hi[N-1:0], dp_lo};

  always @(posedge clock) begin
    if (do_load) begin
      dp_hi    <= '0;
      dp_lo    <= op_b;
      dp_mcand <= op_a;
    end else if (do_shift) begin
      dp_hi <= dp_pair[2*N:N];
      dp_lo <= dp_pair[N-1:0];
    end
  end

  // Per-cycle invariants and counter wrap detection.
  logic prev_is_zero;
  logic prev_preset;
  logic prev_valid = 1'b0;

  always @(negedge clock) begin
    if (reset !== 1'b0) begin
      prev_valid <= 1'b0;
    end else begin
      n_tests = n_tests + 1;
      if ((do_preset && do_decrement) || (do_load && do_shift) || (do_add && !do_shift)) begin
        n_fail = n_fail + 1;
        $display("FAIL strobe_exclusion t=%0t: preset=%b dec=%b load=%b shift=%b add=%b required exclusive and add->shift",
                 $time, do_preset, do_decrement, do_load, do_shift, do_add);
      end
      if (prev_valid && prev_is_zero && !is_zero && !prev_preset) begin
        n_fail = n_fail + 1;
        n_tests = n_tests + 1;
        $display("FAIL counter_wrap t=%0t: is_zero fell without preset, required no wrap", $time);
      end
      prev_is_zero <= is_zero;
      prev_preset  <= do_preset;
      prev_valid   <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Full operation from IDLE: accept, N iterations, hold cycles in DONE,
  // then the out_ready transfer and return to IDLE.
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, input string tag);
    logic [2*N-1:0] exp_prod;
    exp_prod = (2*N)'(a) * (2*N)'(b);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    n_tests = n_tests + 1;
    if ({in_ready, do_load, do_preset, do_shift, busy, out_valid} !== 6'b111000) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_accept: ready/load/preset/shift/busy/ovalid=%b required 111000", tag,
               {in_ready, do_load, do_preset, do_shift, busy, out_valid});
    end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      n_tests = n_tests + 1;
      if ({busy, do_shift, in_ready, out_valid, do_load, do_preset} !== 6'b110000 ||
          do_add !== b[k] || do_decrement !== (k != N - 1)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s_run%0d: busy/shift/ready/ovalid/load/preset=%b add=%b dec=%b required 110000 add=%b dec=%b",
                 tag, k, {busy, do_shift, in_ready, out_valid, do_load, do_preset},
                 do_add, do_decrement, b[k], (k != N - 1));
      end
      step();
    end
    for (int h = 0; h < hold; h++) begin
      #1;
      n_tests = n_tests + 1;
      if ({out_valid, in_ready, busy, do_load, do_add, do_shift, do_preset, do_decrement} !== 8'b10000000) begin
        n_fail = n_fail + 1;
        $display("FAIL %s_hold%0d: ovalid/ready/busy/strobes=%b required 10000000", tag, h,
                 {out_valid, in_ready, busy, do_load, do_add, do_shift, do_preset, do_decrement});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_tests = n_tests + 1;
    if (out_valid !== 1'b1 || product !== exp_prod) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_done: out_valid=%b product=%0d required 1 and %0d", tag, out_valid, product, exp_prod);
    end
    step();
    out_ready = 1'b0;
    #1;
    n_tests = n_tests + 1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_idle: ready/ovalid/busy=%b%b%b required 100", tag, in_ready, out_valid, busy);
    end
    $display("[TB] op %s a=%0d b=%0d hold=%0d product=%0d expected=%0d", tag, a, b, hold, product, exp_prod);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests = n_tests + 1;
      if ({in_ready, out_valid, busy, do_load, do_add, do_shift, do_preset, do_decrement} !== 8'b10000000) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_idle%0d: ready/ovalid/busy/strobes=%b required 10000000", i,
                 {in_ready, out_valid, busy, do_load, do_add, do_shift, do_preset, do_decrement});
      end
      step();
    end
    $display("[TB] reset: idle checked for 3 cycles");
  endtask

  task automatic test_mult13();
    drive_op(N'($urandom_range(0, 15)), 4'd13, 0, "mult13");
  endtask

  task automatic test_backpressure();
    drive_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 5, "backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      drive_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_back_to_back();
    int last_accept;
    int n_accept;
    int cnt;
    last_accept = -1;
    n_accept = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    op_a = N'($urandom);
    op_b = N'($urandom);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (do_load === 1'b1) begin
        n_tests = n_tests + 1;
        if (in_ready !== 1'b1) begin
          n_fail = n_fail + 1;
          $display("FAIL b2b_load_outside_idle cycle=%0d: in_ready=%b required 1", c, in_ready);
        end
        if (last_accept >= 0) begin
          n_tests = n_tests + 1;
          if (c - last_accept !== N + 2) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_gap cycle=%0d: gap=%0d required %0d", c, c - last_accept, N + 2);
          end
        end
        last_accept = c;
        n_accept = n_accept + 1;
        $display("[TB] b2b accept at cycle %0d", c);
      end
      step();
    end
    n_tests = n_tests + 1;
    if (n_accept !== 4) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_accept_count: got %0d required 4", n_accept);
    end
    in_valid = 1'b0;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    n_tests = n_tests + 1;
    if (in_ready !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL b2b_drain: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen_ovalid;
    seen_ovalid = 0;
    op_a = N'($urandom);
    op_b = N'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_tests = n_tests + 1;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || do_shift !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL midrun_reset: ready/busy/ovalid/shift=%b%b%b%b required 1000",
               in_ready, busy, out_valid, do_shift);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen_ovalid = 1;
      step();
    end
    n_tests = n_tests + 1;
    if (seen_ovalid !== 0) begin
      n_fail = n_fail + 1;
      $display("FAIL midrun_no_ovalid: out_valid seen=%0d required 0", seen_ovalid);
    end
    $display("[TB] reset mid-RUN returned to IDLE");
    drive_op(N'($urandom), N'($urandom), 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mult13();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
